// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-bundle input and encoded-word output handshakes of instr_encoder.
interface instr_encoder_if #(parameter int ADDR_W = 8);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    modport master (
        output in_valid, fmt, opcode, funct3, rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err
    );
    modport slave (
        input  in_valid, fmt, opcode, funct3, rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I I/S/B/J fields into instruction words through an address-tagged FIFO.
// Define RANGE_CHECK_EN to flag out-of-range or misaligned immediates on out_err.
module instr_encoder #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 2
) (
    input logic          clk,
    input logic          rst_n,
    instr_encoder_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    logic [31:0]       mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       enc;
    logic              valid, push, pop;
    assign enc = bus.fmt == 2'b00 ? {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode}
               : bus.fmt == 2'b01 ? {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode}
               : bus.fmt == 2'b10 ? {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                                     bus.imm[4:1], bus.imm[11], bus.opcode}
               : {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.opcode};
    assign valid         = count != '0;
    assign bus.in_ready  = count != (PW+1)'(DEPTH);
    assign bus.out_valid = valid;
    assign bus.out_instr = valid ? mem[rd_ptr] : '0;
    assign bus.out_addr  = addr;
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = valid & bus.out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            addr   <= BASE_ADDR;
        end else begin
            count  <= count + (PW+1)'(push) - (PW+1)'(pop);
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            addr   <= addr + ADDR_W'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc;
    end
`ifdef RANGE_CHECK_EN
    logic err_mem [DEPTH];
    logic err;
    // in range iff every bit above the format's sign bit equals it
    assign err = bus.fmt == 2'b11 ? !(&bus.imm[31:20] || !(|bus.imm[31:20])) || bus.imm[0]
               : bus.fmt == 2'b10 ? !(&bus.imm[31:12] || !(|bus.imm[31:12])) || bus.imm[0]
               : !(&bus.imm[31:11] || !(|bus.imm[31:11]));
    always_ff @(posedge clk) begin
        if (push) err_mem[wr_ptr] <= err;
    end
    assign bus.out_err = valid & err_mem[rd_ptr];
`else
    logic unused_imm;
    assign unused_imm  = ^bus.imm[31:21];
    assign bus.out_err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors against a queue-based model of the encoder FIFO.
module tb_instr_encoder;
    localparam int AW = 2;
    localparam int DEPTH = 2;
`ifdef RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    instr_encoder_if #(.ADDR_W(AW)) bus();
    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(2'd0), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int tests = 0;
    int fails = 0;
    typedef struct {logic [31:0] instr; logic err;} ent_t;
    ent_t q[$];
    logic [AW-1:0] maddr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
        return (v >> lo) & ((32'h1 << (hi - lo + 1)) - 32'h1);
    endfunction

    function automatic logic [31:0] model_enc(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [31:0] imm);
        logic [31:0] o, d, s1, s2, ff;
        o = 32'(op); d = 32'(rd) << 7; ff = 32'(f3) << 12; s1 = 32'(rs1) << 15; s2 = 32'(rs2) << 20;
        case (f)
            2'd0: return o | d | ff | s1 | (fld(imm, 11, 0) << 20);
            2'd1: return o | ff | s1 | s2 | (fld(imm, 4, 0) << 7) | (fld(imm, 11, 5) << 25);
            2'd2: return o | ff | s1 | s2 | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7)
                         | (fld(imm, 10, 5) << 25) | (fld(imm, 12, 12) << 31);
            default: return o | d | (fld(imm, 19, 12) << 12) | (fld(imm, 11, 11) << 20)
                            | (fld(imm, 10, 1) << 21) | (fld(imm, 20, 20) << 31);
        endcase
    endfunction

    function automatic logic model_err(input logic [1:0] f, input logic [31:0] imm);
        int v;
        bit bad;
        v = int'(imm);
        case (f)
            2'd2: bad = v < -4096 || v > 4094 || v % 2 != 0;
            2'd3: bad = v < -(1 << 20) || v > (1 << 20) - 2 || v % 2 != 0;
            default: bad = v < -2048 || v > 2047;
        endcase
        return RC && bad;
    endfunction

    always @(negedge rst_n) begin
        q.delete();
        maddr = '0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            automatic bit pu = bus.in_valid && q.size() < DEPTH;
            automatic bit po = bus.out_ready && q.size() > 0;
            if (po) begin
                q.delete(0);
                maddr++;
            end
            if (pu) q.push_back('{model_enc(bus.fmt, bus.opcode, bus.funct3, bus.rd, bus.rs1, bus.rs2, bus.imm),
                                  model_err(bus.fmt, bus.imm)});
        end
    end

    always @(negedge clk) begin
        check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        check("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
        check("out_addr", 32'(bus.out_addr), 32'(maddr));
        if (q.size() > 0) begin
            check("out_instr", bus.out_instr, q[0].instr);
            check("out_err", 32'(bus.out_err), 32'(q[0].err));
        end else begin
            check("out_instr_empty", bus.out_instr, 32'h0);
            check("out_err_empty", 32'(bus.out_err), 32'h0);
        end
    end

    task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        bus.fmt = f; bus.opcode = op; bus.funct3 = f3; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1 bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.fmt = '0; bus.opcode = '0; bus.funct3 = '0;
        bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_instr", bus.out_instr, 32'h0);
        check("rst_addr", 32'(bus.out_addr), 32'd0);
        check("rst_err", 32'(bus.out_err), 32'd0);
        rst_n = 1'b1;
        check("pin_addi", model_enc(2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd7), 32'h00700093);
        check("pin_sw", model_enc(2'd1, 7'h23, 3'd2, 5'd0, 5'd0, 5'd4, 32'd25), 32'h00402CA3);
        check("pin_beq", model_enc(2'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd4, 32'd8), 32'h00400463);
        check("pin_jal", model_enc(2'd3, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'd16), 32'h010000EF);
        // single ADDI, visible one cycle after acceptance
        bus.out_ready = 1'b1;
        send(2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd7);
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        check("t1_instr", bus.out_instr, 32'h00700093);
        check("t1_addr", 32'(bus.out_addr), 32'd0);
        @(posedge clk); #1;
        do_reset();
        // SW then BEQ held in the buffer, then drained in order
        bus.out_ready = 1'b0;
        send(2'd1, 7'h23, 3'd2, 5'd0, 5'd0, 5'd4, 32'd25);
        send(2'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd4, 32'd8);
        check("t2_full", 32'(bus.in_ready), 32'd0);
        check("t2_sw", bus.out_instr, 32'h00402CA3);
        check("t2_sw_addr", 32'(bus.out_addr), 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("t2_beq", bus.out_instr, 32'h00400463);
        check("t2_beq_addr", 32'(bus.out_addr), 32'd1);
        @(posedge clk); #1;
        check("t2_empty", 32'(bus.out_valid), 32'd0);
        send(2'd3, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'd16);
        check("t3_jal", bus.out_instr, 32'h010000EF);
        check("t3_err", 32'(bus.out_err), 32'd0);
        check("t3_addr", 32'(bus.out_addr), 32'd2);
        @(posedge clk); #1;
        do_reset();
        // backpressure: third bundle waits until the full buffer drains
        bus.out_ready = 1'b0;
        send(2'd0, 7'h13, 3'd1, 5'd2, 5'd3, 5'd0, 32'hFFFF_FFFF);
        send(2'd1, 7'h23, 3'd2, 5'd0, 5'd5, 5'd6, 32'hFFFF_F800);
        check("t4_full", 32'(bus.in_ready), 32'd0);
        fork
            send(2'd2, 7'h63, 3'd1, 5'd0, 5'd7, 5'd8, 32'hFFFF_F000);
            begin
                repeat (3) @(posedge clk);
                #1 check("t4_still_full", 32'(bus.in_ready), 32'd0);
                bus.out_ready = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        check("t4_drained", 32'(bus.out_valid), 32'd0);
        check("t4_addr", 32'(bus.out_addr), 32'd3);
        do_reset();
        // immediate range and alignment boundaries
        bus.out_ready = 1'b1;
        send(2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        check("t5_i2048", 32'(bus.out_err), 32'(RC));
        send(2'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd4, 32'd7);
        check("t5_b7", 32'(bus.out_err), 32'(RC));
        send(2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800);
        check("t5_im2048", 32'(bus.out_err), 32'd0);
        send(2'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd4, 32'd4094);
        check("t5_b4094", 32'(bus.out_err), 32'd0);
        send(2'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd4, 32'd4096);
        check("t5_b4096", 32'(bus.out_err), 32'(RC));
        send(2'd3, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFF0_0000);
        check("t5_jmin", 32'(bus.out_err), 32'd0);
        send(2'd3, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0010_0000);
        check("t5_jover", 32'(bus.out_err), 32'(RC));
        send(2'd1, 7'h23, 3'd2, 5'd0, 5'd1, 5'd2, 32'hFFFF_F7FF);
        check("t5_sunder", 32'(bus.out_err), 32'(RC));
        @(posedge clk); #1;
        do_reset();
        // address wrap, then asynchronous reset with words buffered
        for (int i = 0; i < 5; i++) begin
            send(2'd0, 7'h13, 3'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i));
            check("t6_addr", 32'(bus.out_addr), 32'(i % 4));
        end
        bus.out_ready = 1'b0;
        send(2'd0, 7'h13, 3'd0, 5'd9, 5'd0, 5'd0, 32'd9);
        check("t6_full", 32'(bus.in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_addr", 32'(bus.out_addr), 32'd0);
        check("t6_rst_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
